// File: rtl/rram_seq_pkg.sv
// Shared types and constants for the RRAM operation sequencer:
// command opcodes, FSM state codes, line codes and the per-op bias table.
package rram_seq_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_SET   = 2'b01,
        OP_RESET = 2'b10,
        OP_ADC   = 2'b11
    } op_e;

    // FSM state codes
    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_SETUP   = 4'd1;
    localparam logic [3:0] ST_PRE     = 4'd2;
    localparam logic [3:0] ST_SENSE   = 4'd3;
    localparam logic [3:0] ST_PULSE   = 4'd4;
    localparam logic [3:0] ST_CONV    = 4'd5;
    localparam logic [3:0] ST_CAPTURE = 4'd6;
    localparam logic [3:0] ST_DISCH   = 4'd7;
    localparam logic [3:0] ST_RESP    = 4'd8;

    // Driver phase seen by the line encoder
    typedef enum logic [1:0] {
        PH_OFF   = 2'b00,   // everything floating, selects off
        PH_BIAS  = 2'b01,   // op bias applied
        PH_DISCH = 2'b10    // every line grounded, selects off
    } phase_e;

    // Per-line {IN1,IN0} codes; 2'b11 is never produced
    localparam logic [1:0] LC_FLOAT = 2'b00;
    localparam logic [1:0] LC_GND   = 2'b01;
    localparam logic [1:0] LC_DRV   = 2'b10;

    // One-hot voltage selects, bit 0 = V1
    localparam logic [3:0] SEL_NONE = 4'b0000;
    localparam logic [3:0] SEL_V1   = 4'b0001;
    localparam logic [3:0] SEL_V2   = 4'b0010;
    localparam logic [3:0] SEL_V3   = 4'b0100;

    typedef struct packed {
        logic [3:0] sel_wl;
        logic [3:0] sel_bl;
        logic [3:0] sel_sl;
        logic [1:0] code_bl;
        logic [1:0] code_sl;
    } bias_t;

    // Bias table: which voltage each driver selects and which code the
    // addressed bit/source lines receive for a given operation.
    function automatic bias_t bias_for(op_e op);
        bias_t b;
        case (op)
            OP_SET:   b = '{sel_wl: SEL_V2, sel_bl: SEL_V3,   sel_sl: SEL_NONE,
                            code_bl: LC_DRV, code_sl: LC_GND};
            OP_RESET: b = '{sel_wl: SEL_V2, sel_bl: SEL_NONE, sel_sl: SEL_V3,
                            code_bl: LC_GND, code_sl: LC_DRV};
            default:  b = '{sel_wl: SEL_V1, sel_bl: SEL_V1,   sel_sl: SEL_NONE,
                            code_bl: LC_DRV, code_sl: LC_GND};
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rram_line_encoder.sv
// Combinational translation of op/row/column-mask/phase into the per-line
// {IN1,IN0} codes and one-hot voltage selects for the WL, BL and SL drivers.
module rram_line_encoder
    import rram_seq_pkg::*;
(
    input  logic [1:0]  phase,
    input  logic [1:0]  op,
    input  logic [3:0]  row,
    input  logic [15:0] col_mask,
    output logic [3:0]  sel_wl,
    output logic [3:0]  sel_bl,
    output logic [3:0]  sel_sl,
    output logic [15:0] in1_wl,
    output logic [15:0] in0_wl,
    output logic [15:0] in1_bl,
    output logic [15:0] in0_bl,
    output logic [15:0] in1_sl,
    output logic [15:0] in0_sl
);

    bias_t       bias;
    logic [15:0] row_hot;

    assign bias    = bias_for(op_e'(op));
    assign row_hot = 16'd1 << row;

    // Codes: selected WL drives, other WLs ground; addressed BL/SL lines take
    // the op code, unaddressed ones float. Discharge grounds every line.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        sel_wl = SEL_NONE;
        sel_bl = SEL_NONE;
        sel_sl = SEL_NONE;
        in1_wl = '0;
        in0_wl = '0;
        in1_bl = '0;
        in0_bl = '0;
        in1_sl = '0;
        in0_sl = '0;
        case (phase_e'(phase))
            PH_BIAS: begin
                sel_wl = bias.sel_wl;
                sel_bl = bias.sel_bl;
                sel_sl = bias.sel_sl;
                in1_wl = row_hot;
                in0_wl = ~row_hot;
                in1_bl = bias.code_bl[1] ? col_mask : 16'h0000;
                in0_bl = bias.code_bl[0] ? col_mask : 16'h0000;
                in1_sl = bias.code_sl[1] ? col_mask : 16'h0000;
                in0_sl = bias.code_sl[0] ? col_mask : 16'h0000;
            end
            PH_DISCH: begin
                in0_wl = '1;
                in0_bl = '1;
                in0_sl = '1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rram_op_sequencer.sv
// Command sequencer in front of the RRAM analog macro. Accepts one
// READ/SET/RESET/ADC command at a time, steps the array through its timed
// phases with fully registered controls and returns a captured response.
module rram_op_sequencer
    import rram_seq_pkg::*;
#(
    parameter int SETUP_CYC = 4,
    parameter int PRE_CYC   = 2,
    parameter int SENSE_CYC = 2,
    parameter int PULSE_CYC = 8,
    parameter int ADC_CYC   = 4,
    parameter int DISCH_CYC = 2,
    parameter int CNT_W     = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [1:0]  CMD_OP,
    input  logic [3:0]  CMD_ROW,
    input  logic [15:0] CMD_COL_MASK,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [15:0] RSP_CSA,
    output logic [47:0] RSP_ADC,
    output logic        ENABLE_WL,
    output logic        ENABLE_BL,
    output logic        ENABLE_SL,
    output logic        V1_WL, V2_WL, V3_WL, V4_WL,
    output logic        V1_BL, V2_BL, V3_BL, V4_BL,
    output logic        V1_SL, V2_SL, V3_SL, V4_SL,
    output logic [15:0] IN1_WL,
    output logic [15:0] IN0_WL,
    output logic [15:0] IN1_BL,
    output logic [15:0] IN0_BL,
    output logic [15:0] IN1_SL,
    output logic [15:0] IN0_SL,
    output logic        ENABLE_CSA,
    output logic        PRE,
    output logic        SAEN_CSA,
    output logic        REF_CSA,
    output logic [1:0]  CLK_EN_ADC,
    input  logic [15:0] CSA,
    input  logic [15:0] ADC_OUT0,
    input  logic [15:0] ADC_OUT1,
    input  logic [15:0] ADC_OUT2
);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PRE_LD   = CNT_W'(PRE_CYC - 1);
    localparam logic [CNT_W-1:0] SENSE_LD = CNT_W'(SENSE_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] ADC_LD   = CNT_W'(ADC_CYC - 1);
    localparam logic [CNT_W-1:0] DISCH_LD = CNT_W'(DISCH_CYC - 1);

    // Sequencing state
    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [3:0]       row_q, row_d;
    logic [15:0]      mask_q, mask_d;
    logic [15:0]      rsp_csa_q, rsp_csa_d;
    logic [47:0]      rsp_adc_q, rsp_adc_d;

    // Registered outputs
    logic        rsp_valid_q, rsp_valid_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        en_wl_q, en_wl_d;
    logic        en_bl_q, en_bl_d;
    logic        en_sl_q, en_sl_d;
    logic [3:0]  sel_wl_q, sel_wl_d;
    logic [3:0]  sel_bl_q, sel_bl_d;
    logic [3:0]  sel_sl_q, sel_sl_d;
    logic [15:0] in1_wl_q, in1_wl_d, in0_wl_q, in0_wl_d;
    logic [15:0] in1_bl_q, in1_bl_d, in0_bl_q, in0_bl_d;
    logic [15:0] in1_sl_q, in1_sl_d, in0_sl_q, in0_sl_d;
    logic        en_csa_q, en_csa_d;
    logic        pre_q, pre_d;
    logic        saen_q, saen_d;
    logic        ref_q, ref_d;
    logic [1:0]  clk_en_adc_q, clk_en_adc_d;

    logic       accept;
    logic       cnt_done;
    logic       is_prog;
    logic       bias_on;
    logic [1:0] phase_d;

    // CMD_READY is only ever high in IDLE, so it doubles as the idle qualifier
    assign accept   = CMD_VALID && cmd_ready_q;
    assign cnt_done = (cnt_q == '0);
    assign is_prog  = (op_q == OP_SET) || (op_q == OP_RESET);

    // FSM, phase counter, command latch and response capture
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        row_d     = row_q;
        mask_d    = mask_q;
        rsp_csa_d = rsp_csa_q;
        rsp_adc_d = rsp_adc_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d      = CMD_OP;
                    row_d     = CMD_ROW;
                    mask_d    = CMD_COL_MASK;
                    rsp_csa_d = '0;
                    rsp_adc_d = '0;
                    // An empty column mask has nothing to touch: answer at once
                    if (CMD_COL_MASK == 16'h0000) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_SETUP;
                        cnt_d   = SETUP_LD;
                    end
                end
            end
            ST_SETUP: begin
                if (!cnt_done) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (is_prog) begin
                    state_d = ST_PULSE;
                    cnt_d   = PULSE_LD;
                end else begin
                    state_d = ST_PRE;
                    cnt_d   = PRE_LD;
                end
            end
            ST_PRE: begin
                if (!cnt_done) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (op_q == OP_ADC) begin
                    state_d = ST_CONV;
                    cnt_d   = ADC_LD;
                end else begin
                    state_d = ST_SENSE;
                    cnt_d   = SENSE_LD;
                end
            end
            ST_SENSE, ST_CONV: begin
                if (!cnt_done) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_PULSE: begin
                if (!cnt_done) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ST_DISCH;
                    cnt_d   = DISCH_LD;
                end
            end
            ST_CAPTURE: begin
                rsp_csa_d = CSA & mask_q;
                rsp_adc_d = (op_q == OP_ADC) ? {ADC_OUT2, ADC_OUT1, ADC_OUT0} : 48'h0;
                state_d   = ST_DISCH;
                cnt_d     = DISCH_LD;
            end
            ST_DISCH: begin
                if (!cnt_done) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_valid_q && RSP_READY) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state so every control is a flop output
    always_comb begin
        bias_on = (state_d == ST_SETUP) || (state_d == ST_PRE) ||
                  (state_d == ST_SENSE) || (state_d == ST_PULSE) ||
                  (state_d == ST_CONV)  || (state_d == ST_CAPTURE);
        phase_d = bias_on               ? PH_BIAS  :
                  (state_d == ST_DISCH) ? PH_DISCH : PH_OFF;

        en_wl_d = bias_on && (state_d != ST_SETUP);
        en_bl_d = bias_on || (state_d == ST_DISCH);
        en_sl_d = bias_on || (state_d == ST_DISCH);

        pre_d    = (state_d == ST_PRE);
        saen_d   = (state_d == ST_SENSE);
        ref_d    = (state_d == ST_SENSE);
        en_csa_d = (state_d == ST_SENSE) || (state_d == ST_CONV);

        // ADC phase clocks start at 01 on CONV entry and swap every cycle
        clk_en_adc_d = 2'b00;
        if (state_d == ST_CONV) begin
            clk_en_adc_d = (state_q == ST_CONV) ? {clk_en_adc_q[0], clk_en_adc_q[1]} : 2'b01;
        end

        rsp_valid_d = (state_d == ST_RESP);
        cmd_ready_d = (state_d == ST_IDLE);
    end

    rram_line_encoder u_line_encoder (
        .phase    (phase_d),
        .op       (op_d),
        .row      (row_d),
        .col_mask (mask_d),
        .sel_wl   (sel_wl_d),
        .sel_bl   (sel_bl_d),
        .sel_sl   (sel_sl_d),
        .in1_wl   (in1_wl_d),
        .in0_wl   (in0_wl_d),
        .in1_bl   (in1_bl_d),
        .in0_bl   (in0_bl_d),
        .in1_sl   (in1_sl_d),
        .in0_sl   (in0_sl_d)
    );

    // State and output registers; reset drops every driver immediately
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            row_q        <= '0;
            mask_q       <= '0;
            rsp_csa_q    <= '0;
            rsp_adc_q    <= '0;
            rsp_valid_q  <= 1'b0;
            cmd_ready_q  <= 1'b0;
            en_wl_q      <= 1'b0;
            en_bl_q      <= 1'b0;
            en_sl_q      <= 1'b0;
            sel_wl_q     <= '0;
            sel_bl_q     <= '0;
            sel_sl_q     <= '0;
            in1_wl_q     <= '0;
            in0_wl_q     <= '0;
            in1_bl_q     <= '0;
            in0_bl_q     <= '0;
            in1_sl_q     <= '0;
            in0_sl_q     <= '0;
            en_csa_q     <= 1'b0;
            pre_q        <= 1'b0;
            saen_q       <= 1'b0;
            ref_q        <= 1'b0;
            clk_en_adc_q <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            row_q        <= row_d;
            mask_q       <= mask_d;
            rsp_csa_q    <= rsp_csa_d;
            rsp_adc_q    <= rsp_adc_d;
            rsp_valid_q  <= rsp_valid_d;
            cmd_ready_q  <= cmd_ready_d;
            en_wl_q      <= en_wl_d;
            en_bl_q      <= en_bl_d;
            en_sl_q      <= en_sl_d;
            sel_wl_q     <= sel_wl_d;
            sel_bl_q     <= sel_bl_d;
            sel_sl_q     <= sel_sl_d;
            in1_wl_q     <= in1_wl_d;
            in0_wl_q     <= in0_wl_d;
            in1_bl_q     <= in1_bl_d;
            in0_bl_q     <= in0_bl_d;
            in1_sl_q     <= in1_sl_d;
            in0_sl_q     <= in0_sl_d;
            en_csa_q     <= en_csa_d;
            pre_q        <= pre_d;
            saen_q       <= saen_d;
            ref_q        <= ref_d;
            clk_en_adc_q <= clk_en_adc_d;
        end
    end

    assign CMD_READY  = cmd_ready_q;
    assign RSP_VALID  = rsp_valid_q;
    assign RSP_CSA    = rsp_csa_q;
    assign RSP_ADC    = rsp_adc_q;
    assign ENABLE_WL  = en_wl_q;
    assign ENABLE_BL  = en_bl_q;
    assign ENABLE_SL  = en_sl_q;
    assign {V4_WL, V3_WL, V2_WL, V1_WL} = sel_wl_q;
    assign {V4_BL, V3_BL, V2_BL, V1_BL} = sel_bl_q;
    assign {V4_SL, V3_SL, V2_SL, V1_SL} = sel_sl_q;
    assign IN1_WL     = in1_wl_q;
    assign IN0_WL     = in0_wl_q;
    assign IN1_BL     = in1_bl_q;
    assign IN0_BL     = in0_bl_q;
    assign IN1_SL     = in1_sl_q;
    assign IN0_SL     = in0_sl_q;
    assign ENABLE_CSA = en_csa_q;
    assign PRE        = pre_q;
    assign SAEN_CSA   = saen_q;
    assign REF_CSA    = ref_q;
    assign CLK_EN_ADC = clk_en_adc_q;

endmodule

// File: tb/tb_rram_op_sequencer.sv
// Scoreboard bench for rram_op_sequencer: directed commands push expected
// responses; a monitor compares each response as RSP_VALID rises.
module tb_rram_op_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [1:0]  CMD_OP = '0;
    logic [3:0]  CMD_ROW = '0;
    logic [15:0] CMD_COL_MASK = '0;
    logic        RSP_VALID;
    logic        RSP_READY = 1'b1;
    logic [15:0] RSP_CSA;
    logic [47:0] RSP_ADC;
    logic        ENABLE_WL, ENABLE_BL, ENABLE_SL;
    logic        V1_WL, V2_WL, V3_WL, V4_WL;
    logic        V1_BL, V2_BL, V3_BL, V4_BL;
    logic        V1_SL, V2_SL, V3_SL, V4_SL;
    logic [15:0] IN1_WL, IN0_WL, IN1_BL, IN0_BL, IN1_SL, IN0_SL;
    logic        ENABLE_CSA, PRE, SAEN_CSA, REF_CSA;
    logic [1:0]  CLK_EN_ADC;
    logic [15:0] CSA = 16'hFFFF;
    logic [15:0] ADC_OUT0 = 16'h1111;
    logic [15:0] ADC_OUT1 = 16'h2222;
    logic [15:0] ADC_OUT2 = 16'h4444;

    rram_op_sequencer dut (
        .CLK(CLK), .RST_N(RST_N),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
        .CMD_ROW(CMD_ROW), .CMD_COL_MASK(CMD_COL_MASK),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
        .RSP_CSA(RSP_CSA), .RSP_ADC(RSP_ADC),
        .ENABLE_WL(ENABLE_WL), .ENABLE_BL(ENABLE_BL), .ENABLE_SL(ENABLE_SL),
        .V1_WL(V1_WL), .V2_WL(V2_WL), .V3_WL(V3_WL), .V4_WL(V4_WL),
        .V1_BL(V1_BL), .V2_BL(V2_BL), .V3_BL(V3_BL), .V4_BL(V4_BL),
        .V1_SL(V1_SL), .V2_SL(V2_SL), .V3_SL(V3_SL), .V4_SL(V4_SL),
        .IN1_WL(IN1_WL), .IN0_WL(IN0_WL), .IN1_BL(IN1_BL), .IN0_BL(IN0_BL),
        .IN1_SL(IN1_SL), .IN0_SL(IN0_SL),
        .ENABLE_CSA(ENABLE_CSA), .PRE(PRE), .SAEN_CSA(SAEN_CSA), .REF_CSA(REF_CSA),
        .CLK_EN_ADC(CLK_EN_ADC), .CSA(CSA),
        .ADC_OUT0(ADC_OUT0), .ADC_OUT1(ADC_OUT1), .ADC_OUT2(ADC_OUT2)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] csa;
        logic [47:0] adc;
        int          exp_edge;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    // Activity observed on falling edges
    int         enwl_cnt = 0;
    int         saen_cnt = 0;
    int         adc_n = 0;
    logic [7:0] adc_seq = '0;
    logic       any_act = 1'b0;
    int         viol = 0;

    logic [3:0] sel_wl, sel_bl, sel_sl;
    assign sel_wl = {V4_WL, V3_WL, V2_WL, V1_WL};
    assign sel_bl = {V4_BL, V3_BL, V2_BL, V1_BL};
    assign sel_sl = {V4_SL, V3_SL, V2_SL, V1_SL};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (ENABLE_WL) enwl_cnt++;
        if (SAEN_CSA)  saen_cnt++;
        if (CLK_EN_ADC != 2'b00) begin
            adc_seq = {adc_seq[5:0], CLK_EN_ADC};
            adc_n++;
        end
        if (ENABLE_WL || ENABLE_BL || ENABLE_SL || PRE || ENABLE_CSA || SAEN_CSA ||
            (sel_wl | sel_bl | sel_sl) != 4'b0 ||
            (IN1_WL | IN0_WL | IN1_BL | IN0_BL | IN1_SL | IN0_SL) != 16'h0)
            any_act = 1'b1;
        if (!$onehot0(sel_wl) || !$onehot0(sel_bl) || !$onehot0(sel_sl)) viol++;
        if ((IN1_WL & IN0_WL) != 16'h0 || (IN1_BL & IN0_BL) != 16'h0 ||
            (IN1_SL & IN0_SL) != 16'h0) viol++;
    end

    // Response monitor: compare on each rising edge of RSP_VALID
    logic prev_valid = 1'b0;
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (RSP_VALID && !prev_valid) begin
            check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("rsp_edge", 64'(cyc), 64'(e.exp_edge));
                check("rsp_csa", 64'(RSP_CSA), 64'(e.csa));
                check("rsp_adc", 64'(RSP_ADC), 64'(e.adc));
            end
        end
        prev_valid = RSP_VALID;
    end

    task automatic clear_obs();
        enwl_cnt = 0;
        saen_cnt = 0;
        adc_n    = 0;
        adc_seq  = '0;
        any_act  = 1'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] row, input logic [15:0] mask,
                        input logic [15:0] ecsa, input logic [47:0] eadc, input int lat);
        int n = 0;
        @(negedge CLK);
        while (!CMD_READY && n < 60) begin
            @(negedge CLK);
            n++;
        end
        check("cmd_ready_before_send", 64'(CMD_READY), 64'd1);
        CMD_OP       = op;
        CMD_ROW      = row;
        CMD_COL_MASK = mask;
        CMD_VALID    = 1'b1;
        sb.push_back('{csa: ecsa, adc: eadc, exp_edge: cyc + 1 + lat});
        @(negedge CLK);
        CMD_VALID = 1'b0;
    endtask

    task automatic wait_enwl();
        int n = 0;
        while (!ENABLE_WL && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check("enable_wl_seen", 64'(ENABLE_WL), 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!CMD_READY && n < 80) begin
            @(negedge CLK);
            n++;
        end
        check("back_to_idle", 64'(CMD_READY), 64'd1);
    endtask

    initial begin
        int   n;
        logic bad_valid, bad_data, bad_ready;

        // Reset values
        #12;
        check("rst_cmd_ready", 64'(CMD_READY), 64'd0);
        check("rst_rsp_valid", 64'(RSP_VALID), 64'd0);
        check("rst_drivers", 64'({ENABLE_WL, ENABLE_BL, ENABLE_SL, sel_wl, sel_bl, sel_sl}), 64'd0);
        check("rst_codes", 64'(IN1_WL | IN0_WL | IN1_BL | IN0_BL | IN1_SL | IN0_SL), 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check("ready_after_release", 64'(CMD_READY), 64'd1);

        // READ row 3, mask 0x00F0
        clear_obs();
        send(2'b00, 4'd3, 16'h00F0, 16'h00F0, 48'h0, 11);
        wait_enwl();
        check("read_in1_wl", 64'(IN1_WL), 64'h0008);
        check("read_in0_wl", 64'(IN0_WL), 64'hFFF7);
        check("read_sel_wl", 64'(sel_wl), 64'b0001);
        check("read_sel_bl", 64'(sel_bl), 64'b0001);
        check("read_in1_bl", 64'(IN1_BL), 64'h00F0);
        check("read_in0_sl", 64'(IN0_SL), 64'h00F0);
        wait_idle();
        check("read_saen_cycles", 64'(saen_cnt), 64'd2);
        check("read_enwl_cycles", 64'(enwl_cnt), 64'd5);

        // SET row 0, mask 0x0001
        clear_obs();
        send(2'b01, 4'd0, 16'h0001, 16'h0, 48'h0, 14);
        wait_enwl();
        check("set_sel_wl", 64'(sel_wl), 64'b0010);
        check("set_sel_bl", 64'(sel_bl), 64'b0100);
        check("set_in1_bl", 64'(IN1_BL), 64'h0001);
        check("set_in0_sl", 64'(IN0_SL), 64'h0001);
        wait_idle();
        check("set_enwl_cycles", 64'(enwl_cnt), 64'd8);

        // RESET row 15, mask 0x8001
        clear_obs();
        send(2'b10, 4'd15, 16'h8001, 16'h0, 48'h0, 14);
        wait_enwl();
        check("reset_in1_sl", 64'(IN1_SL), 64'h8001);
        check("reset_in0_bl", 64'(IN0_BL), 64'h8001);
        check("reset_sel_bl", 64'(sel_bl), 64'b0000);
        check("reset_sel_sl", 64'(sel_sl), 64'b0100);
        check("reset_in1_wl", 64'(IN1_WL), 64'h8000);
        wait_idle();

        // ADC row 5, mask 0x0F0F
        clear_obs();
        send(2'b11, 4'd5, 16'h0F0F, 16'h0F0F, 48'h4444_2222_1111, 13);
        wait_idle();
        check("adc_clk_en_count", 64'(adc_n), 64'd4);
        check("adc_clk_en_seq", 64'(adc_seq), 64'b01_10_01_10);
        check("adc_enwl_cycles", 64'(enwl_cnt), 64'd7);

        // Response back-pressure: RSP_READY low for 5 cycles
        CSA       = 16'hA5A5;
        RSP_READY = 1'b0;
        send(2'b00, 4'd1, 16'hFFFF, 16'hA5A5, 48'h0, 11);
        n = 0;
        while (!RSP_VALID && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check("stall_rsp_seen", 64'(RSP_VALID), 64'd1);
        bad_valid = 1'b0;
        bad_data  = 1'b0;
        bad_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (RSP_VALID !== 1'b1) bad_valid = 1'b1;
            if (RSP_CSA !== 16'hA5A5 || RSP_ADC !== 48'h0) bad_data = 1'b1;
            if (CMD_READY !== 1'b0) bad_ready = 1'b1;
        end
        check("stall_valid_held", 64'(bad_valid), 64'd0);
        check("stall_data_stable", 64'(bad_data), 64'd0);
        check("stall_cmd_ready_low", 64'(bad_ready), 64'd0);
        RSP_READY = 1'b1;
        wait_idle();
        CSA = 16'hFFFF;

        // Empty mask: response right away, no analog activity
        clear_obs();
        send(2'b00, 4'd4, 16'h0000, 16'h0, 48'h0, 0);
        wait_idle();
        check("mask0_no_activity", 64'(any_act), 64'd0);

        // Reset in the middle of a SET pulse
        send(2'b01, 4'd2, 16'h00FF, 16'h0, 48'h0, 14);
        wait_enwl();
        #2;
        RST_N = 1'b0;
        #1;
        check("midrst_enables", 64'({ENABLE_WL, ENABLE_BL, ENABLE_SL}), 64'd0);
        check("midrst_selects", 64'({sel_wl, sel_bl, sel_sl}), 64'd0);
        check("midrst_codes", 64'(IN1_WL | IN0_WL | IN1_BL | IN0_BL | IN1_SL | IN0_SL), 64'd0);
        check("midrst_ctrl", 64'({PRE, SAEN_CSA, CLK_EN_ADC, RSP_VALID, CMD_READY}), 64'd0);
        sb.delete();
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check("midrst_ready_after", 64'(CMD_READY), 64'd1);

        // Normal READ after the mid-operation reset
        clear_obs();
        send(2'b00, 4'd7, 16'h0003, 16'h0003, 48'h0, 11);
        wait_idle();
        check("post_rst_saen_cycles", 64'(saen_cnt), 64'd2);

        repeat (3) @(negedge CLK);
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("invariants", 64'(viol), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
